// File: rtl/posit_recip_seq.sv
// Posit reciprocal sequencer: Newton-Raphson x' = x*(2 - m*x) on a shared external multiplier.
// Optional stall counter output perf_stall is enabled by defining POSIT_RECIP_PERF_CNT_EN.

module seed_lookup #(
    parameter int N  = 16,
    parameter int ES = 3
) (
    input  logic [N-1:0] i_mag,
    output logic [N-1:0] o_seed,
    output logic [N-1:0] o_shifted
);
    logic          w_r;
    logic          w_done;
    logic [N-1:0]  w_run;
    logic [N-1:0]  w_k;
    logic [N-1:0]  w_body;
    logic [ES-1:0] w_exp;

    always_comb begin
        w_r    = i_mag[N-2];
        w_run  = '0;
        w_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_done) begin
                if (i_mag[i] == w_r) w_run = w_run + N'(1);
                else                 w_done = 1'b1;
            end
        end
        w_k = w_r ? (w_run - N'(1)) : (N'(0) - w_run);
        // Drop the regime run and its terminator; exponent then fraction end up MSB-aligned.
        w_body    = {i_mag[N-2:0], 1'b0} << (w_run + N'(1));
        w_exp     = w_body[N-1 -: ES];
        o_shifted = w_body;
        o_seed    = (w_k << ES) + N'(w_exp);
    end
endmodule

module posit_recip_seq #(
    parameter int           N      = 16,
    parameter int           ES     = 3,
    parameter int           ITERS  = 2,
    parameter logic [N-1:0] INIT_X = 16'h5A82
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    output logic           mul_req,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic           mul_ack,
    input  logic [2*N-1:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_sign,
    output logic           out_special,
    output logic [N-1:0]   out_scale,
`ifdef POSIT_RECIP_PERF_CNT_EN
    output logic [15:0]    perf_stall,
`endif
    output logic [N-1:0]   out_frac
);
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_MUL_A = 3'd2,
        S_SUB   = 3'd3,
        S_MUL_B = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_data;
    logic [N-1:0]    r_mag;
    logic [N-1:0]    r_m;
    logic [N-1:0]    r_x;
    logic [N-1:0]    r_pq;
    logic [N-1:0]    r_t;
    logic [CW-1:0]   r_cnt;
    logic            r_sign;
    logic            r_special;
    logic [N-1:0]    r_scale;
    logic [N-1:0]    r_frac;

    logic [N-1:0]    w_seed;
    logic [N-1:0]    w_shifted;
    logic [N-1:0]    w_m;
    logic [N-1:0]    w_pq;
    logic            w_is_special;
    logic            w_unused_bits;

    seed_lookup #(.N(N), .ES(ES)) u_seed (
        .i_mag     (r_mag),
        .o_seed    (w_seed),
        .o_shifted (w_shifted)
    );

    // Hidden bit, then the fraction bits that follow the exponent field.
    assign w_m           = N'({1'b1, w_shifted[N-1-ES:0]}) << (ES - 1);
    assign w_pq          = mul_p[2*N-2:N-1];
    assign w_is_special  = (r_data[N-2:0] == '0);
    assign w_unused_bits = ^{mul_p[2*N-1], mul_p[N-2:0], w_shifted[N-1:N-ES]};

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign mul_req     = (r_state == S_MUL_A) || (r_state == S_MUL_B);
    assign mul_a       = (r_state == S_MUL_A) ? r_m : ((r_state == S_MUL_B) ? r_x : '0);
    assign mul_b       = (r_state == S_MUL_A) ? r_x : ((r_state == S_MUL_B) ? r_t : '0);
    assign out_sign    = r_sign;
    assign out_special = r_special;
    assign out_scale   = r_scale;
    assign out_frac    = r_frac;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_mag     <= '0;
            r_m       <= '0;
            r_x       <= '0;
            r_pq      <= '0;
            r_t       <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_special <= 1'b0;
            r_scale   <= '0;
            r_frac    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data    <= in_data;
                        r_sign    <= in_data[N-1];
                        r_mag     <= in_data[N-1] ? -in_data : in_data;
                        r_special <= 1'b0;
                        r_scale   <= '0;
                        r_frac    <= '0;
                        r_state   <= S_SEED;
                    end
                end
                S_SEED: begin
                    if (w_is_special) begin
                        // Zero and NaR share one encoding pattern apart from the sign bit.
                        r_special <= 1'b1;
                        r_sign    <= r_data[N-1];
                        r_frac    <= '0;
                        r_scale   <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_m     <= w_m;
                        r_scale <= -w_seed;
                        r_x     <= INIT_X;
                        r_cnt   <= '0;
                        r_state <= S_MUL_A;
                    end
                end
                S_MUL_A: begin
                    if (mul_ack) begin
                        r_pq    <= w_pq;
                        r_state <= S_SUB;
                    end
                end
                S_SUB: begin
                    r_t     <= -r_pq;
                    r_state <= S_MUL_B;
                end
                S_MUL_B: begin
                    if (mul_ack) begin
                        r_x <= w_pq;
                        if (r_cnt == CW'(ITERS - 1)) begin
                            r_frac  <= w_pq;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= S_MUL_A;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef POSIT_RECIP_PERF_CNT_EN
    logic [15:0] r_perf;
    assign perf_stall = r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if ((r_state == S_IDLE) && in_valid) begin
            r_perf <= '0;
        end else if (mul_req && !mul_ack && (r_perf != 16'hFFFF)) begin
            r_perf <= r_perf + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_posit_recip_seq.sv
// Self-checking bench for posit_recip_seq: directed vector table, reset/stray-ack sequence,
// and random operands against a behavioural posit-decode + Newton-Raphson model.

module tb_posit_recip_seq;
    localparam int N     = 16;
    localparam int ES    = 3;
    localparam int ITERS = 2;
    localparam int INITX = 16'h5A82;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          mul_req;
    logic [N-1:0]  mul_a;
    logic [N-1:0]  mul_b;
    logic          mul_ack;
    logic [31:0]   mul_p;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic          out_special;
    logic [N-1:0]  out_scale;
    logic [N-1:0]  out_frac;
`ifdef POSIT_RECIP_PERF_CNT_EN
    logic [15:0]   perf_stall;
`endif

    posit_recip_seq #(.N(N), .ES(ES), .ITERS(ITERS), .INIT_X(16'h5A82)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mul_req     (mul_req),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ack     (mul_ack),
        .mul_p       (mul_p),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sign    (out_sign),
        .out_special (out_special),
        .out_scale   (out_scale),
`ifdef POSIT_RECIP_PERF_CNT_EN
        .perf_stall  (perf_stall),
`endif
        .out_frac    (out_frac)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ops_q[$];

    int          first_delay = -1;
    bit          rand_mode   = 0;
    bit          stray       = 0;
    bit          in_req      = 0;
    int          wcnt        = 0;
    int          cur_delay   = 0;
    int          stall_cnt   = 0;
    int          req_cycles  = 0;
    logic [N-1:0] sa, sb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // External multiplier: optional wait cycles, then a one-cycle ack with the full product.
    always @(negedge clk) begin
        if (rst) begin
            mul_ack = 1'b0;
            in_req  = 1'b0;
        end else if (!mul_req) begin
            in_req  = 1'b0;
            mul_ack = stray;
            mul_p   = 32'h1234_5678;
            stray   = 1'b0;
        end else begin
            req_cycles++;
            if (!in_req) begin
                in_req = 1'b1;
                wcnt   = 0;
                sa     = mul_a;
                sb     = mul_b;
                if (first_delay >= 0) cur_delay = first_delay;
                else if (rand_mode)   cur_delay = $urandom_range(0, 3);
                else                  cur_delay = 0;
                first_delay = -1;
            end else begin
                check("mul_a_stable", {16'h0, mul_a}, {16'h0, sa});
                check("mul_b_stable", {16'h0, mul_b}, {16'h0, sb});
            end
            if (wcnt >= cur_delay) begin
                mul_ack = 1'b1;
                mul_p   = {16'h0, mul_a} * {16'h0, mul_b};
                ops_q.push_back({mul_a, mul_b});
                in_req  = 1'b0;
            end else begin
                mul_ack = 1'b0;
                wcnt++;
                stall_cnt++;
            end
        end
    end

    // Reference: decode the posit by reading its bit string, then iterate with integer arithmetic.
    task automatic model(input logic [15:0] d, output logic e_sign, output logic e_spec,
                         output logic [15:0] e_scale, output logic [15:0] e_frac);
        longint mag, run, k, rem, tail, e, fcnt, frac, m, x, p, t, seed, rbit;
        exp_q.delete();
        if (d == 16'h0000 || d == 16'h8000) begin
            e_spec = 1'b1; e_sign = (d != 0); e_scale = 16'h0; e_frac = 16'h0;
            return;
        end
        e_spec = 1'b0;
        e_sign = d[15];
        mag  = d[15] ? (65536 - longint'(d)) : longint'(d);
        rbit = (mag >> 14) & 1;
        run  = 0;
        while (run < 15 && (((mag >> (14 - run)) & 1) == rbit)) run++;
        k    = rbit ? run - 1 : -run;
        rem  = (run >= 14) ? 0 : 14 - run;
        tail = mag & ((longint'(1) << rem) - 1);
        if (rem >= ES) begin
            e    = tail >> (rem - ES);
            fcnt = rem - ES;
            frac = tail & ((longint'(1) << fcnt) - 1);
        end else begin
            e    = tail << (ES - rem);
            fcnt = 0;
            frac = 0;
        end
        seed    = k * (1 << ES) + e;
        e_scale = 16'(-seed);
        m = 32768 + (frac << (15 - fcnt));
        x = INITX;
        for (int it = 0; it < ITERS; it++) begin
            exp_q.push_back({m[15:0], x[15:0]});
            p = ((m * x) >> 15) & 65535;
            t = (65536 - p) & 65535;
            exp_q.push_back({x[15:0], t[15:0]});
            x = ((x * t) >> 15) & 65535;
        end
        e_frac = x[15:0];
    endtask

    task automatic run_op(input logic [15:0] d, input int hold, input logic e_sign,
                          input logic e_spec, input logic [15:0] e_scale,
                          input logic [15:0] e_frac, input int e_lat, input bit add_stalls);
        int g;
        int lat;
        ops_q.delete();
        stall_cnt  = 0;
        req_cycles = 0;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("in_ready_before_accept", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, add_stalls ? e_lat + stall_cnt : e_lat);
        check("out_sign", {31'h0, out_sign}, {31'h0, e_sign});
        check("out_special", {31'h0, out_special}, {31'h0, e_spec});
        check("out_scale", {16'h0, out_scale}, {16'h0, e_scale});
        check("out_frac", {16'h0, out_frac}, {16'h0, e_frac});
        if (e_spec) begin
            check("special_no_req", req_cycles, 0);
        end else begin
            check("op_count", ops_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < ops_q.size(); i++)
                check($sformatf("operands_%0d", i), ops_q[i], exp_q[i]);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'h0, out_valid}, 32'h1);
            check("hold_in_ready", {31'h0, in_ready}, 32'h0);
            check("hold_frac", {16'h0, out_frac}, {16'h0, e_frac});
            check("hold_scale", {16'h0, out_scale}, {16'h0, e_scale});
        end
`ifdef POSIT_RECIP_PERF_CNT_EN
        check("perf_stall", {16'h0, perf_stall}, stall_cnt);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", {31'h0, in_ready}, 32'h1);
        check("post_hs_out_valid", {31'h0, out_valid}, 32'h0);
    endtask

    typedef struct {
        logic [15:0] d;
        int          hold;
        int          fd;
        logic        s;
        logic        sp;
        logic [15:0] sc;
        logic [15:0] fr;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic        m_s, m_sp;
        logic [15:0] m_sc, m_fr;
        logic [15:0] rd;
        int          base;

        vecs[0] = '{16'h4000, 0, -1, 1'b0, 1'b0, 16'h0000, 16'h7F0E, 8};
        vecs[1] = '{16'hC000, 0, -1, 1'b1, 1'b0, 16'h0000, 16'h7F0E, 8};
        vecs[2] = '{16'h0000, 0, -1, 1'b0, 1'b1, 16'h0000, 16'h0000, 2};
        vecs[3] = '{16'h8000, 0, -1, 1'b1, 1'b1, 16'h0000, 16'h0000, 2};
        vecs[4] = '{16'h4000, 4,  5, 1'b0, 1'b0, 16'h0000, 16'h7F0E, 13};
        vecs[5] = '{16'h5000, 0, -1, 1'b0, 1'b0, 16'hFFFC, 16'h7F0E, 8};
        vecs[6] = '{16'h2000, 1, -1, 1'b0, 1'b0, 16'h0008, 16'h7F0E, 8};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        mul_ack   = 1'b0;
        mul_p     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_mul_req", {31'h0, mul_req}, 32'h0);
        check("rst_out_sign", {31'h0, out_sign}, 32'h0);
        check("rst_out_special", {31'h0, out_special}, 32'h0);
        check("rst_out_scale", {16'h0, out_scale}, 32'h0);
        check("rst_out_frac", {16'h0, out_frac}, 32'h0);
`ifdef POSIT_RECIP_PERF_CNT_EN
        check("rst_perf_stall", {16'h0, perf_stall}, 32'h0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            model(vecs[i].d, m_s, m_sp, m_sc, m_fr);
            first_delay = vecs[i].fd;
            run_op(vecs[i].d, vecs[i].hold, vecs[i].s, vecs[i].sp, vecs[i].sc, vecs[i].fr,
                   vecs[i].lat, 1'b0);
        end

        // Reset while the second multiply-by-M request is pending.
        in_valid = 1'b1;
        in_data  = 16'h4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_mul_req", {31'h0, mul_req}, 32'h1);
        check("mid_mul_a", {16'h0, mul_a}, 32'h8000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_mul_req", {31'h0, mul_req}, 32'h0);
        check("abort_in_ready", {31'h0, in_ready}, 32'h1);
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        stray = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("stray_in_ready", {31'h0, in_ready}, 32'h1);
        check("stray_out_valid", {31'h0, out_valid}, 32'h0);
        check("stray_mul_req", {31'h0, mul_req}, 32'h0);
        model(16'h4000, m_s, m_sp, m_sc, m_fr);
        run_op(16'h4000, 0, 1'b0, 1'b0, 16'h0000, 16'h7F0E, 8, 1'b0);

        // Random operands with random multiplier wait states and backpressure.
        rand_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            rd = 16'($urandom_range(0, 65535));
            model(rd, m_s, m_sp, m_sc, m_fr);
            base = m_sp ? 2 : 2 + 3 * ITERS;
            run_op(rd, $urandom_range(0, 2), m_s, m_sp, m_sc, m_fr, base, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
